// File: rtl/nim_vga_pkg.sv
// rtl/nim_vga_pkg.sv - 640x480@60 raster constants and decode helper
package nim_vga_pkg;

  localparam logic [9:0] H_ACTIVE = 10'd640;
  localparam logic [9:0] H_FP     = 10'd16;
  localparam logic [9:0] H_SYNC   = 10'd96;
  localparam logic [9:0] H_BP     = 10'd48;
  localparam logic [9:0] H_TOTAL  = 10'd800;

  localparam logic [9:0] V_ACTIVE = 10'd480;
  localparam logic [9:0] V_FP     = 10'd10;
  localparam logic [9:0] V_SYNC   = 10'd2;
  localparam logic [9:0] V_BP     = 10'd33;
  localparam logic [9:0] V_TOTAL  = 10'd525;

  localparam logic [9:0] H_MAX        = H_TOTAL - 10'd1;
  localparam logic [9:0] V_MAX        = V_TOTAL - 10'd1;
  localparam logic [9:0] H_SYNC_START = H_ACTIVE + H_FP;
  localparam logic [9:0] H_SYNC_END   = H_ACTIVE + H_FP + H_SYNC - 10'd1;
  localparam logic [9:0] V_SYNC_START = V_ACTIVE + V_FP;
  localparam logic [9:0] V_SYNC_END   = V_ACTIVE + V_FP + V_SYNC - 10'd1;

  function automatic logic in_span(input logic [9:0] v, input logic [9:0] lo,
                                   input logic [9:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/pix_strobe_gen.sv
// rtl/pix_strobe_gen.sv - free-running prescaler producing a one-clk pixel strobe
module pix_strobe_gen #(
  parameter int unsigned DIV_LOG2 = 2
) (
  input  logic clk,
  input  logic rst,
  output logic pix_en
);

  // Strobe is registered, so it lands in the cycle where div is all-ones.
  localparam logic [DIV_LOG2-1:0] DIV_TERM = DIV_LOG2'((1 << DIV_LOG2) - 2);

  logic [DIV_LOG2-1:0] div;

  always_ff @(posedge clk) begin
    if (rst) begin
      div    <= '0;
      pix_en <= 1'b0;
    end else begin
      div    <= div + 1'b1;
      pix_en <= (div == DIV_TERM);
    end
  end

endmodule

// File: rtl/vga_timing_ctrl.sv
// rtl/vga_timing_ctrl.sv - raster counters and sync/blank decode for 640x480@60
module vga_timing_ctrl
  import nim_vga_pkg::*;
#(
  parameter int unsigned DIV_LOG2 = 2,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_en,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       frame_start
);

  logic [9:0] h_cnt, v_cnt;
  logic [9:0] h_nxt, v_nxt;
  logic       frame_nxt;

  pix_strobe_gen #(.DIV_LOG2(DIV_LOG2)) u_strobe (
    .clk    (clk),
    .rst    (rst),
    .pix_en (pix_en)
  );

  always_comb begin
    h_nxt     = h_cnt;
    v_nxt     = v_cnt;
    frame_nxt = 1'b0;
    if (pix_en) begin
      if (h_cnt == H_MAX) begin
        h_nxt = '0;
        if (v_cnt == V_MAX) begin
          v_nxt     = '0;
          frame_nxt = 1'b1;
        end else begin
          v_nxt = v_cnt + 10'd1;
        end
      end else begin
        h_nxt = h_cnt + 10'd1;
      end
    end
  end

  // Decode from the next-state counters so outputs line up with x/y.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      video_on    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      h_cnt       <= h_nxt;
      v_cnt       <= v_nxt;
      frame_start <= frame_nxt;
      if (pix_en) begin
        hsync    <= in_span(h_nxt, H_SYNC_START, H_SYNC_END) ? SYNC_POL : ~SYNC_POL;
        vsync    <= in_span(v_nxt, V_SYNC_START, V_SYNC_END) ? SYNC_POL : ~SYNC_POL;
        video_on <= (h_nxt < H_ACTIVE) && (v_nxt < V_ACTIVE);
      end
    end
  end

  assign x = h_cnt;
  assign y = v_cnt;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb/tb_vga_timing_ctrl.sv - self-checking bench for vga_timing_ctrl (both sync polarities)
module tb_vga_timing_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pix0, hs0, vs0, von0, fs0;
  logic       pix1, hs1, vs1, von1, fs1;
  logic [9:0] x0, y0, x1, y1;

  vga_timing_ctrl #(.DIV_LOG2(2), .SYNC_POL(1'b0)) u0 (
    .clk(clk), .rst(rst), .pix_en(pix0), .hsync(hs0), .vsync(vs0),
    .video_on(von0), .x(x0), .y(y0), .frame_start(fs0)
  );

  vga_timing_ctrl #(.DIV_LOG2(2), .SYNC_POL(1'b1)) u1 (
    .clk(clk), .rst(rst), .pix_en(pix1), .hsync(hs1), .vsync(vs1),
    .video_on(von1), .x(x1), .y(y1), .frame_start(fs1)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         edge_n;
    logic       pix;
    logic [9:0] xv;
    logic       von;
  } cad_t;

  cad_t cad[8];

  int vectors = 0;
  int miscompares = 0;

  // Reference state: edges since reset release and the pixel position.
  int n = 0;
  int mx = 0, my = 0;
  bit m_pix, m_hs, m_vs, m_von, m_fs, last_adv;
  int skip = 0;
  logic [9:0] fh, fv;

  task automatic model_step();
    last_adv = 1'b0;
    m_fs     = 1'b0;
    if (rst) begin
      n = 0; mx = 0; my = 0;
      m_pix = 0; m_hs = 0; m_vs = 0; m_von = 0;
    end else begin
      n++;
      m_pix = (n % 4 == 3);
      if (n % 4 == 0) begin
        last_adv = 1'b1;
        if (mx == 799) begin
          mx = 0;
          my = (my == 524) ? 0 : my + 1;
        end else begin
          mx = mx + 1;
        end
        m_fs  = (mx == 0) && (my == 0);
        m_hs  = (mx >= 656) && (mx <= 751);
        m_vs  = (my >= 490) && (my <= 491);
        m_von = (mx < 640) && (my < 480);
      end
    end
  endtask

  task automatic check_model();
    logic [24:0] exp0, exp1, act0, act1;
    exp0 = {m_pix, 10'(mx), 10'(my), ~m_hs, ~m_vs, m_von, m_fs};
    exp1 = {m_pix, 10'(mx), 10'(my),  m_hs,  m_vs, m_von, m_fs};
    act0 = {pix0, x0, y0, hs0, vs0, von0, fs0};
    act1 = {pix1, x1, y1, hs1, vs1, von1, fs1};
    vectors += 2;
    if (act0 !== exp0) begin
      miscompares++;
      $display("FAIL model_pol0 n=%0d {pix,x,y,hs,vs,von,fs} got %h expected %h", n, act0, exp0);
    end
    if (act1 !== exp1) begin
      miscompares++;
      $display("FAIL model_pol1 n=%0d {pix,x,y,hs,vs,von,fs} got %h expected %h", n, act1, exp1);
    end
  endtask

  task automatic cmp(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (skip == 0) check_model();
    else skip--;
  endtask

  task automatic timeout(input string name);
    miscompares++;
    vectors++;
    $display("FAIL %s: cycle budget expired", name);
  endtask

  // Teleport the raster to (h,v) right after an advance edge; the first
  // three edges afterwards carry stale sync/blank and are not compared.
  task automatic jump(input int h, input int v);
    int guard;
    guard = 0;
    while (!last_adv && guard < 16) begin
      tick();
      guard++;
    end
    fh = 10'(h);
    fv = 10'(v);
    force u0.h_cnt = fh;
    force u0.v_cnt = fv;
    force u1.h_cnt = fh;
    force u1.v_cnt = fv;
    mx   = h;
    my   = v;
    skip = 3;
    tick();
    release u0.h_cnt;
    release u0.v_cnt;
    release u1.h_cnt;
    release u1.v_cnt;
    tick();
    tick();
    tick();
  endtask

  task automatic run_cadence(input string tag);
    for (int i = 0; i < 8; i++) begin
      tick();
      cmp({tag, "_pix"}, int'(pix0), int'(cad[i].pix));
      cmp({tag, "_x"},   int'(x0),   int'(cad[i].xv));
      cmp({tag, "_von"}, int'(von0), int'(cad[i].von));
    end
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int guard;
    int hs_fall, hs_rise, von_fall, vs_fall, vs_rise, fs_cnt;
    logic p_hs, p_von, p_vs;

    cad[0] = '{1, 1'b0, 10'd0, 1'b0};
    cad[1] = '{2, 1'b0, 10'd0, 1'b0};
    cad[2] = '{3, 1'b1, 10'd0, 1'b0};
    cad[3] = '{4, 1'b0, 10'd1, 1'b1};
    cad[4] = '{5, 1'b0, 10'd1, 1'b1};
    cad[5] = '{6, 1'b0, 10'd1, 1'b1};
    cad[6] = '{7, 1'b1, 10'd1, 1'b1};
    cad[7] = '{8, 1'b0, 10'd2, 1'b1};

    rst = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    cmp("reset_hsync_pol0", int'(hs0), 1);
    cmp("reset_hsync_pol1", int'(hs1), 0);
    rst = 1'b0;
    run_cadence("cadence");

    // One full line: sync/blank edges and the line wrap.
    hs_fall = -1; hs_rise = -1; von_fall = -1;
    p_hs = hs0; p_von = von0;
    guard = 0;
    while (!(mx == 0 && my == 1) && guard < 4000) begin
      tick();
      if (p_hs && !hs0) hs_fall = int'(x0);
      if (!p_hs && hs0) hs_rise = int'(x0);
      if (p_von && !von0) von_fall = int'(x0);
      p_hs = hs0; p_von = von0;
      guard++;
    end
    if (guard >= 4000) timeout("line_run");
    cmp("hsync_fall_x", hs_fall, 656);
    cmp("hsync_rise_x", hs_rise, 752);
    cmp("video_off_x", von_fall, 640);
    cmp("line_wrap_x", int'(x0), 0);
    cmp("line_wrap_y", int'(y0), 1);

    // Vertical sync window.
    jump(0, 486);
    vs_fall = -1; vs_rise = -1;
    p_vs = vs0;
    guard = 0;
    while (my != 493 && guard < 30000) begin
      tick();
      if (p_vs && !vs0) vs_fall = int'(y0);
      if (!p_vs && vs0) vs_rise = int'(y0);
      p_vs = vs0;
      guard++;
    end
    if (guard >= 30000) timeout("vsync_run");
    cmp("vsync_fall_y", vs_fall, 490);
    cmp("vsync_rise_y", vs_rise, 492);

    // Frame wrap and a single-clk frame_start.
    jump(780, 524);
    fs_cnt = 0;
    guard = 0;
    while (!fs0 && guard < 200) begin
      tick();
      guard++;
    end
    if (guard >= 200) timeout("frame_wrap");
    cmp("wrap_x", int'(x0), 0);
    cmp("wrap_y", int'(y0), 0);
    for (int i = 0; i < 12; i++) begin
      tick();
      if (fs0) fs_cnt++;
    end
    cmp("frame_start_single", fs_cnt, 0);

    // Random positions, run lengths and reset pulses.
    for (int k = 0; k < 8; k++) begin
      jump(int'($urandom_range(0, 799)), int'($urandom_range(0, 524)));
      for (int i = 0; i < int'($urandom_range(100, 2500)); i++) tick();
      if ($urandom_range(0, 1) == 1) begin
        rst = 1'b1;
        for (int i = 0; i < int'($urandom_range(1, 3)); i++) tick();
        rst = 1'b0;
        for (int i = 0; i < 40; i++) tick();
      end
    end

    // Mid-frame reset then an identical restart.
    jump(700, 300);
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    cmp("midrst_x", int'(x0), 0);
    cmp("midrst_y", int'(y0), 0);
    cmp("midrst_von", int'(von0), 0);
    cmp("midrst_hsync_pol1", int'(hs1), 0);
    rst = 1'b0;
    run_cadence("restart");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
